// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request, fixed wait states, one-cycle response.
// Define DMEM_MISALIGN_CHECK_EN to fault misaligned accesses instead of aligning them down.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_next;
    logic [4:0]  count;
    logic        lat_write, lat_unsigned;
    logic [1:0]  lat_size;
    logic [63:0] lat_addr, lat_wdata;

    logic        accept, finish;
    logic [IDX_W-1:0] idx;
    logic        out_of_range, fault;
    logic [2:0]  size_mask, offset;
    logic [7:0]  byte_base, byte_en;
    logic [63:0] bit_mask, old_word, shifted_wdata, merged, lane, load_data;

    // NOTE: storage has no reset; only control state and response registers are reset.
    logic [63:0] mem [DEPTH_WORDS];

    assign accept = (state == S_IDLE) && req_valid;
    assign finish = (state == S_WAIT) && (count == 5'd1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (req_valid) state_next = S_WAIT;
            S_WAIT:  if (count == 5'd1) state_next = S_RESP;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == S_IDLE);
        resp_valid = (state == S_RESP);
    end

    // The extra count covers the array read/merge cycle ahead of the wait states.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count        <= '0;
            lat_write    <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_size     <= '0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
        end else if (accept) begin
            count        <= 5'(WAIT_CYCLES + 1);
            lat_write    <= req_write;
            lat_unsigned <= req_unsigned;
            lat_size     <= req_size;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
        end else if (state == S_WAIT) begin
            count <= count - 5'd1;
        end
    end

    assign idx          = lat_addr[IDX_W+2:3];
    assign out_of_range = |lat_addr[63:IDX_W+3];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        size_mask = 3'b000;
        byte_base = 8'hFF;
        case (lat_size)
            2'b00: begin size_mask = 3'b111; byte_base = 8'h01; end
            2'b01: begin size_mask = 3'b110; byte_base = 8'h03; end
            2'b10: begin size_mask = 3'b100; byte_base = 8'h0F; end
            default: ;
        endcase
    end

    assign offset = lat_addr[2:0] & size_mask;

`ifdef DMEM_MISALIGN_CHECK_EN
    assign fault = out_of_range | (|(lat_addr[2:0] & ~size_mask));
`else
    assign fault = out_of_range;
`endif

    assign byte_en = byte_base << offset;

    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < 8; i++) bit_mask[8*i +: 8] = {8{byte_en[i]}};
    end

    assign old_word      = mem[idx];
    assign shifted_wdata = lat_wdata << {offset, 3'b000};
    assign merged        = (old_word & ~bit_mask) | (shifted_wdata & bit_mask);
    assign lane          = old_word >> {offset, 3'b000};

    always_comb begin
        load_data = lane;
        case (lat_size)
            2'b00: load_data = {{56{~lat_unsigned & lane[7]}},  lane[7:0]};
            2'b01: load_data = {{48{~lat_unsigned & lane[15]}}, lane[15:0]};
            2'b10: load_data = {{32{~lat_unsigned & lane[31]}}, lane[31:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (finish) begin
            resp_err   <= fault;
            resp_rdata <= (fault || lat_write) ? 64'd0 : load_data;
        end
    end

    // Stores commit on the edge entering RESP; an async reset in WAIT clears state first.
    always_ff @(posedge clock) begin
        if (finish && lat_write && !fault) mem[idx] <= merged;
    end
endmodule
